icache_axi_bridge: RTL and testbench
====================================

# icache_axi_bridge

Memory-side bridge directly downstream of the 4-way instruction/data cache. It accepts the cache's SRAM-like line request (`sen`/`wen`/`addr`), runs one AXI4 INCR burst of a full cache line (read refill or dirty write-back), and returns per-word handshakes. At the end of the line it raises a one-cycle `burst` completion pulse, which the cache FSM uses to leave its WB/RD states.

## Interface
- `LINE_WORDS`, default 16: words per cache line and beats per burst; a power of two, ≤256.
- `AXI_ID`, default 0: constant value driven on `arid`/`awid`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `sen`  in  1  cache request, held until `addr_ok`.
- `wen`  in  1  1 = write-back line, 0 = refill line; sampled with `sen`.
- `addr`  in  32  line-aligned byte address; low log2(LINE_WORDS)+2 bits are zero.
- `wdata`  in  32  write-back word for the current beat.
- `addr_ok`  out  1  request accepted, one-cycle pulse.
- `data_ok`  out  1  one word transferred, one-cycle pulse per beat.
- `sdata`  out  32  refill word, valid while `data_ok`=1 on a read.
- `beat_idx`  out  log2(LINE_WORDS)  word index within the line of the current `data_ok`.
- `burst`  out  1  line transfer complete, one-cycle pulse.
- AXI AR: `arid` 4, `araddr` 32, `arlen` 8, `arsize` 3, `arburst` 2 (out); `arvalid` out 1; `arready` in 1.
- AXI R: `rdata` in 32, `rlast` in 1, `rvalid` in 1, `rresp` in 2; `rready` out 1.
- AXI AW: `awid`, `awaddr`, `awlen`, `awsize`, `awburst` (out); `awvalid` out 1; `awready` in 1.
- AXI W: `wdata_o` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1; `wready` in 1.
- AXI B: `bvalid` in 1, `bresp` in 2; `bready` out 1.

## Operation
- States: IDLE, AR, R, AW, W, B.
- IDLE:
  - If `sen`=1, pulse `addr_ok` and register `addr` into `araddr`/`awaddr`.
  - Clear the beat counter.
  - Go to AW if `wen`=1, otherwise go to AR.
- AR:
  - Drive `arvalid`=1; hold `araddr` stable until `arready`.
  - On `arvalid & arready`, go to R.
- R:
  - Drive `rready`=1.
  - On each `rvalid`, in the next cycle: `sdata`←`rdata`, `beat_idx`←counter, `data_ok`=1; then increment the counter.
  - On a beat with `rlast`, additionally pulse `burst` in the same cycle as that beat's `data_ok`, then go to IDLE.
- AW:
  - Drive `awvalid`=1; on `awready`, go to W.
- W:
  - Drive `wvalid`=1, `wdata_o`=`wdata` (combinational pass-through), `wstrb`=4'hF, `wlast`=(counter==LINE_WORDS-1).
  - `data_ok` = `wvalid & wready`, combinational, so the cache presents the next word in the following cycle.
  - `beat_idx`=counter.
  - Counter increments on each handshake; after the `wlast` handshake, go to B.
- B:
  - Drive `bready`=1; on `bvalid`, pulse `burst` (registered, next cycle) and go to IDLE.
- Constant fields: `arlen`=`awlen`=LINE_WORDS-1, `arsize`=`awsize`=3'b010, `arburst`=`awburst`=2'b01.
- `rresp` and `bresp` are ignored; the line is always treated as complete.

## Timing
- Reset values: state IDLE; counter 0; all valid/ready outputs 0; `addr_ok`, `data_ok`, `burst` 0; `sdata`, `araddr`, `awaddr` 0; `beat_idx` 0.
- Reset asserted mid-burst: return to IDLE immediately and drop all outputs. No completion pulse is produced.
- `sen` while not in IDLE: ignored, no `addr_ok`; the cache keeps holding `sen`.
- Read latency, with zero-wait AXI:
  - `addr_ok` in cycle 0, `arvalid` in cycle 1, first `data_ok` 1 cycle after the first `rvalid`.
  - Final `burst` coincides with the last `data_ok`.
- Write latency:
  - `addr_ok` in cycle 0, `awvalid` in cycle 1.
  - LINE_WORDS `data_ok` pulses during W.
  - `burst` 1 cycle after `bvalid`.
- Gaps in `rvalid`/`wready` produce no `data_ok` pulse; the counter holds.
- `rlast` arriving before the counter wrap still ends the read. The counter wraps modulo LINE_WORDS.

## Structure
- Shared package `axi_pkg`:
  - constants `AXI_BURST_INCR`=2'b01 and `AXI_SIZE_4B`=3'b010;
  - state enum `bridge_state_t`.
- Single module with no sub-modules. The beat counter and registered read capture are inline.

## Test plan
- Refill at `addr`=0x0000_1040, memory word i = 0x1000+i, zero-wait → `araddr`=0x1040, `arlen`=15; 16 `data_ok` pulses with `sdata`=0x1000..0x100F and `beat_idx` 0..15; `burst` coincides with the 16th pulse.
- Write-back at 0x0000_2000 with the cache supplying 0xA0+i, `wready` high every other cycle → 16 W beats with `wdata_o`=0xA0..0xAF; `wlast` only on beat 15; `burst` 1 cycle after `bvalid`.
- `arready` held low for 5 cycles → `arvalid` stays 1 and `araddr` stays stable; no `data_ok`.
- `sen` asserted during an R burst → no `addr_ok` until the cycle after `burst`, then the second request is accepted.
- `rst` asserted at beat 7 of a refill → all outputs 0 the same cycle; state IDLE; a new request after reset starts from beat 0.
- `rresp`=2'b10 on all beats → behaviour identical to OKAY; `burst` is still produced.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants and the bridge FSM state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } bridge_state_t;

endpackage

// File: rtl/icache_axi_bridge.sv
// Cache line request -> single AXI4 INCR burst (refill or write-back), per-word handshakes back to cache.
// Latency: addr_ok same cycle as sen in IDLE; read data_ok 1 cycle after rvalid; write data_ok combinational with wready.
// Backpressure: arready/awready/rvalid/wready/bvalid stalls hold the FSM and beat counter; no data_ok on stall cycles.
module icache_axi_bridge
  import axi_pkg::*;
#(
  parameter int LINE_WORDS = 16,
  parameter int AXI_ID     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  // cache side
  input  logic                          sen,
  input  logic                          wen,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   wdata,
  output logic                          addr_ok,
  output logic                          data_ok,
  output logic [31:0]                   sdata,
  output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
  output logic                          burst,
  // AXI AR
  output logic [3:0]                    arid,
  output logic [31:0]                   araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arvalid,
  input  logic                          arready,
  // AXI R
  input  logic [31:0]                   rdata,
  input  logic                          rlast,
  input  logic                          rvalid,
  input  logic [1:0]                    rresp,
  output logic                          rready,
  // AXI AW
  output logic [3:0]                    awid,
  output logic [31:0]                   awaddr,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic                          awvalid,
  input  logic                          awready,
  // AXI W
  output logic [31:0]                   wdata_o,
  output logic [3:0]                    wstrb,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  // AXI B
  input  logic                          bvalid,
  input  logic [1:0]                    bresp,
  output logic                          bready
);

  localparam int CW = $clog2(LINE_WORDS);

  bridge_state_t state_q, state_d;
  logic [31:0]   addr_q;
  logic [CW-1:0] cnt_q;
  logic          rd_ok_q;
  logic [31:0]   sdata_q;
  logic [CW-1:0] rd_idx_q;
  logic          burst_q;

  // Error responses are deliberately not acted on: the cache always sees a complete line.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};

  // Once the rlast beat is captured, R lingers one cycle with rready low while
  // data_ok/burst are presented, so IDLE is only re-entered after the pulse.
  logic r_hs, w_hs, last_beat;
  assign r_hs      = (state_q == ST_R) & ~burst_q & rvalid;
  assign w_hs      = (state_q == ST_W) & wready;
  assign last_beat = (cnt_q == CW'(LINE_WORDS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (sen)                state_d = wen ? ST_AW : ST_AR;
      ST_AR:   if (arready)            state_d = ST_R;
      ST_R:    if (burst_q)            state_d = ST_IDLE;
      ST_AW:   if (awready)            state_d = ST_W;
      ST_W:    if (wready & last_beat) state_d = ST_B;
      ST_B:    if (bvalid)             state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Line address capture, beat counter, registered read capture and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      cnt_q    <= '0;
      rd_ok_q  <= 1'b0;
      sdata_q  <= '0;
      rd_idx_q <= '0;
      burst_q  <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && sen) addr_q <= addr;
      if (state_q == ST_IDLE)          cnt_q  <= '0;
      else if (r_hs || w_hs)           cnt_q  <= cnt_q + 1'b1;
      rd_ok_q <= r_hs;
      if (r_hs) begin
        sdata_q  <= rdata;
        rd_idx_q <= cnt_q;
      end
      burst_q <= (r_hs & rlast) | ((state_q == ST_B) & bvalid);
    end
  end

  // Output decode
  always_comb begin
    addr_ok  = (state_q == ST_IDLE) & sen;
    arvalid  = (state_q == ST_AR);
    rready   = (state_q == ST_R) & ~burst_q;
    awvalid  = (state_q == ST_AW);
    wvalid   = (state_q == ST_W);
    wdata_o  = (state_q == ST_W) ? wdata : 32'h0;
    wstrb    = (state_q == ST_W) ? 4'hF : 4'h0;
    wlast    = (state_q == ST_W) & last_beat;
    bready   = (state_q == ST_B);
    data_ok  = rd_ok_q | w_hs;
    beat_idx = (state_q == ST_W) ? cnt_q : rd_idx_q;
    sdata    = sdata_q;
    burst    = burst_q;
    araddr   = addr_q;
    awaddr   = addr_q;
    arid     = 4'(AXI_ID);
    awid     = 4'(AXI_ID);
    arlen    = 8'(LINE_WORDS - 1);
    awlen    = 8'(LINE_WORDS - 1);
    arsize   = AXI_SIZE_4B;
    awsize   = AXI_SIZE_4B;
    arburst  = AXI_BURST_INCR;
    awburst  = AXI_BURST_INCR;
  end

endmodule

// File: tb/tb_icache_axi_bridge.sv
// Directed bench for icache_axi_bridge: refill, write-back, AR stall, busy sen, reset mid-burst, error resp.
module tb_icache_axi_bridge;

  logic        clk, rst;
  logic        sen, wen;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok, burst;
  logic [31:0] sdata;
  logic [3:0]  beat_idx;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, awvalid, awready;
  logic [31:0] rdata, wdata_o;
  logic        rlast, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;

  int n_assert = 0;
  int n_fail   = 0;

  icache_axi_bridge #(.LINE_WORDS(16), .AXI_ID(0)) dut (
    .clk(clk), .rst(rst),
    .sen(sen), .wen(wen), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .sdata(sdata), .beat_idx(beat_idx), .burst(burst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rresp(rresp), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata_o(wdata_o), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serves one 16-beat read burst starting in the first cycle of R; beat i carries base+i.
  // With gap set, rvalid is low every other cycle. Returns in the cycle showing the last data_ok.
  task automatic run_rbeats(input logic [31:0] base, input bit gap, input logic [1:0] resp);
    int nxt  = 0;
    int prev = -1;
    int cur;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (nxt <= 15 && !(gap && (cyc % 2 == 1))) begin
        rvalid = 1'b1; rdata = base + nxt; rlast = (nxt == 15); rresp = resp;
        cur = nxt; nxt++;
      end else begin
        rvalid = 1'b0; rlast = 1'b0; cur = -1;
      end
      #1;
      chk("r_addr_ok_busy", addr_ok, 0);
      chk("r_rready", rready, (prev != 15));
      chk("r_data_ok", data_ok, (prev >= 0));
      if (prev >= 0) begin
        chk("r_sdata", sdata, base + prev);
        chk("r_beat_idx", beat_idx, prev);
        chk("r_burst", burst, (prev == 15));
      end
      if (prev == 15) break;
      step();
      prev = cur;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  initial begin
    int b;
    rst = 1'b1; sen = 0; wen = 0; addr = 0; wdata = 0;
    arready = 0; rdata = 0; rlast = 0; rvalid = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    step(); step();

    // Reset state
    chk("rst_addr_ok", addr_ok, 0);   chk("rst_data_ok", data_ok, 0);
    chk("rst_burst", burst, 0);       chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);     chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);     chk("rst_bready", bready, 0);
    chk("rst_sdata", sdata, 0);       chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);     chk("rst_beat_idx", beat_idx, 0);
    rst = 1'b0;

    // Zero-wait refill at 0x1040, memory word i = 0x1000+i
    arready = 1; sen = 1; wen = 0; addr = 32'h0000_1040; #1;
    chk("rd1_addr_ok", addr_ok, 1);
    chk("rd1_arvalid_c0", arvalid, 0);
    step(); sen = 0; #1;
    chk("rd1_addr_ok_c1", addr_ok, 0);
    chk("rd1_arvalid", arvalid, 1);   chk("rd1_araddr", araddr, 32'h1040);
    chk("rd1_arlen", arlen, 15);      chk("rd1_arsize", arsize, 3'b010);
    chk("rd1_arburst", arburst, 2'b01); chk("rd1_arid", arid, 0);
    step();
    run_rbeats(32'h0000_1000, 1'b0, 2'b00);
    step(); #1;
    chk("rd1_done_data_ok", data_ok, 0); chk("rd1_done_burst", burst, 0);
    chk("rd1_done_rready", rready, 0);

    // Refill at 0x3000 with arready low 5 cycles, rvalid gaps, SLVERR on every beat,
    // and a write-back request held during R
    arready = 0; sen = 1; wen = 0; addr = 32'h0000_3000; #1;
    chk("rd2_addr_ok", addr_ok, 1);
    step(); sen = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("ar_stall_arvalid", arvalid, 1); chk("ar_stall_araddr", araddr, 32'h3000);
      chk("ar_stall_data_ok", data_ok, 0); chk("ar_stall_rready", rready, 0);
      step();
    end
    arready = 1; #1;
    chk("ar_stall_arvalid_last", arvalid, 1);
    step(); arready = 0;
    sen = 1; wen = 1; addr = 32'h0000_2000;
    run_rbeats(32'h0000_3100, 1'b1, 2'b10);
    step(); #1;
    chk("busy_sen_accepted", addr_ok, 1);

    // Write-back at 0x2000, wready every other cycle, cache word i = 0xA0+i
    step(); sen = 0; wen = 0; #1;
    chk("wb_awvalid", awvalid, 1);    chk("wb_awaddr", awaddr, 32'h2000);
    chk("wb_awlen", awlen, 15);       chk("wb_awsize", awsize, 3'b010);
    chk("wb_awburst", awburst, 2'b01); chk("wb_awid", awid, 0);
    awready = 1;
    step(); awready = 0;
    b = 0;
    for (int c = 0; c < 32; c++) begin
      wready = (c % 2 == 1); wdata = 32'hA0 + b; #1;
      chk("w_wvalid", wvalid, 1);       chk("w_wdata_o", wdata_o, 32'hA0 + b);
      chk("w_wstrb", wstrb, 4'hF);      chk("w_wlast", wlast, (b == 15));
      chk("w_data_ok", data_ok, wready); chk("w_beat_idx", beat_idx, b);
      chk("w_burst", burst, 0);
      if (wready) b++;
      step();
    end
    wready = 0; #1;
    chk("b_bready", bready, 1); chk("b_wvalid", wvalid, 0); chk("b_burst_wait", burst, 0);
    step(); bvalid = 1; #1;
    chk("b_burst_same_cycle", burst, 0);
    step(); bvalid = 0; #1;
    chk("b_burst_pulse", burst, 1); chk("b_bready_drop", bready, 0);
    step(); #1;
    chk("b_burst_clear", burst, 0);

    // Refill at 0x5000 cut by reset at beat 7
    arready = 1; sen = 1; wen = 0; addr = 32'h0000_5000; #1;
    chk("rd3_addr_ok", addr_ok, 1);
    step(); sen = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      rvalid = 1; rdata = 32'h5000 + i; rlast = 0;
      step();
    end
    rvalid = 0; #1;
    chk("rd3_beat7_data_ok", data_ok, 1); chk("rd3_beat7_idx", beat_idx, 7);
    chk("rd3_beat7_sdata", sdata, 32'h5007);
    rst = 1; #1;
    chk("mid_rst_data_ok", data_ok, 0); chk("mid_rst_rready", rready, 0);
    chk("mid_rst_sdata", sdata, 0);     chk("mid_rst_beat_idx", beat_idx, 0);
    chk("mid_rst_burst", burst, 0);     chk("mid_rst_araddr", araddr, 0);
    chk("mid_rst_arvalid", arvalid, 0);
    step(); rst = 0;
    step();
    chk("post_rst_burst", burst, 0);
    sen = 1; addr = 32'h0000_6000; #1;
    chk("rd4_addr_ok", addr_ok, 1);
    step(); sen = 0; #1;
    chk("rd4_araddr", araddr, 32'h6000);
    step();
    run_rbeats(32'h0000_6000, 1'b0, 2'b00);
    step(); #1;
    chk("rd4_done_burst", burst, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
